// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory bus controller behind the pipeline memory stage.
// Takes one load/store at a time, steers store data onto byte lanes, builds
// byte selects and runs one single-outstanding cycle on the data bus. A
// watchdog aborts bus cycles that the slave never acknowledges.
//
// Build option DMEM_MISALIGN_TRAP_EN: when defined, misaligned or illegal
// accesses skip the bus and complete with o_err=1, o_misalign=1. When it is
// undefined, such accesses are forced to natural alignment (illegal funct3
// becomes a word access) and o_misalign stays 0.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for i_req; decodes and latches the access
// ST_BUS  | o_bus_cyc high, waiting for i_bus_ack or watchdog expiry
// ST_RESP | o_ack high for one cycle with o_rdata / o_err / o_misalign

module dmem_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_wdata,
  output logic        o_ack,
  output logic [31:0] o_rdata,
  output logic        o_err,
  output logic        o_misalign,
  output logic        o_bus_cyc,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [3:0]  o_bus_sel,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_ack,
  input  logic [31:0] i_bus_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Watchdog is a down-counter loaded on BUS entry; expiry is the cycle on
  // which it already reads zero, giving exactly TIMEOUT_CYCLES BUS cycles.
  localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] wdata_q, wdata_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic        mis_q, mis_d;
  logic [31:0] rdata_q, rdata_d;

  logic [1:0]  req_a;
  logic        req_illegal;
  logic        req_trap;
  logic [3:0]  req_sel;
  logic [31:0] req_wdata;

  // Decode the incoming request: legality, byte selects and lane steering.
  always_comb begin
    req_a       = i_addr[1:0];
    // 011, 11x are never legal; stores only have 000/001/010.
    req_illegal = (i_funct3 == 3'b011) || (i_funct3[2:1] == 2'b11) ||
                  (i_we && i_funct3[2]);
    req_sel     = 4'b1111;
    req_wdata   = i_wdata;
    if (!req_illegal) begin
      case (i_funct3[1:0])
        2'b00: begin
          req_sel   = 4'b0001 << req_a;
          req_wdata = {4{i_wdata[7:0]}};
        end
        2'b01: begin
          // Halfword lanes follow a[1] only, so a[0] is ignored here.
          req_sel   = 4'b0011 << {req_a[1], 1'b0};
          req_wdata = {2{i_wdata[15:0]}};
        end
        default: begin
          req_sel   = 4'b1111;
          req_wdata = i_wdata;
        end
      endcase
    end
`ifdef DMEM_MISALIGN_TRAP_EN
    req_trap = req_illegal ||
               ((i_funct3[1:0] == 2'b01) && req_a[0]) ||
               ((i_funct3[1:0] == 2'b10) && (req_a != 2'b00));
`else
    req_trap = 1'b0;
`endif
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;
    ack_d   = 1'b0;
    err_d   = err_q;
    mis_d   = mis_q;
    rdata_d = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (i_req) begin
          if (req_trap) begin
            ack_d   = 1'b1;
            err_d   = 1'b1;
            mis_d   = 1'b1;
            rdata_d = '0;
            state_d = ST_RESP;
          end else begin
            cyc_d   = 1'b1;
            we_d    = i_we;
            addr_d  = {i_addr[31:2], 2'b00};
            sel_d   = req_sel;
            wdata_d = i_we ? req_wdata : '0;
            cnt_d   = TMO_LOAD;
            state_d = ST_BUS;
          end
        end
      end

      ST_BUS: begin
        // An ack on the expiry cycle still completes normally.
        if (i_bus_ack) begin
          rdata_d = we_q ? '0 : i_bus_rdata;
          err_d   = 1'b0;
          mis_d   = 1'b0;
          ack_d   = 1'b1;
          state_d = ST_RESP;
        end else if (cnt_q == 8'd0) begin
          rdata_d = '0;
          err_d   = 1'b1;
          mis_d   = 1'b0;
          ack_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
        if (i_bus_ack || (cnt_q == 8'd0)) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = '0;
          sel_d   = '0;
          wdata_d = '0;
        end
      end

      ST_RESP: begin
        err_d   = 1'b0;
        mis_d   = 1'b0;
        rdata_d = '0;
        state_d = ST_IDLE;
      end

      default: begin
        cyc_d   = 1'b0;
        err_d   = 1'b0;
        mis_d   = 1'b0;
        rdata_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops the bus cycle asynchronously.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      sel_q   <= '0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
      rdata_q <= rdata_d;
    end
  end

  assign o_ack       = ack_q;
  assign o_rdata     = rdata_q;
  assign o_err       = err_q;
  assign o_misalign  = mis_q;
  assign o_bus_cyc   = cyc_q;
  assign o_bus_we    = we_q;
  assign o_bus_addr  = addr_q;
  assign o_bus_sel   = sel_q;
  assign o_bus_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with a short watchdog (TIMEOUT_CYCLES=4).
// Inputs change and outputs are sampled on the falling clock edge.

module tb_dmem_ctrl;

  localparam int unsigned TMO = 4;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_req = 1'b0;
  logic        i_we = 1'b0;
  logic [31:0] i_addr = '0;
  logic [2:0]  i_funct3 = '0;
  logic [31:0] i_wdata = '0;
  logic        o_ack;
  logic [31:0] o_rdata;
  logic        o_err;
  logic        o_misalign;
  logic        o_bus_cyc;
  logic        o_bus_we;
  logic [31:0] o_bus_addr;
  logic [3:0]  o_bus_sel;
  logic [31:0] o_bus_wdata;
  logic        i_bus_ack = 1'b0;
  logic [31:0] i_bus_rdata = '0;

  dmem_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_req       (i_req),
    .i_we        (i_we),
    .i_addr      (i_addr),
    .i_funct3    (i_funct3),
    .i_wdata     (i_wdata),
    .o_ack       (o_ack),
    .o_rdata     (o_rdata),
    .o_err       (o_err),
    .o_misalign  (o_misalign),
    .o_bus_cyc   (o_bus_cyc),
    .o_bus_we    (o_bus_we),
    .o_bus_addr  (o_bus_addr),
    .o_bus_sel   (o_bus_sel),
    .o_bus_wdata (o_bus_wdata),
    .i_bus_ack   (i_bus_ack),
    .i_bus_rdata (i_bus_rdata)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Observations from the last do_xfer call.
  int          x_cyc, x_lat, x_acks, x_unstable;
  logic        x_we, x_err, x_mis, x_err_after;
  logic [31:0] x_addr, x_wdata, x_rdata;
  logic [3:0]  x_sel;

  // Issues one request and plays the slave: ack on the ack_after-th cyc
  // cycle (0 = never). Records cyc length, ack latency from acceptance, etc.
  task automatic do_xfer(input logic we, input logic [31:0] addr,
                         input logic [2:0] f3, input logic [31:0] wd,
                         input int ack_after, input logic [31:0] rd_in);
    bit done;
    int ack_n;
    x_cyc = 0; x_lat = 0; x_acks = 0; x_unstable = 0;
    x_we = 1'bx; x_err = 1'bx; x_mis = 1'bx; x_err_after = 1'bx;
    x_addr = 'x; x_wdata = 'x; x_rdata = 'x; x_sel = 'x;
    done = 1'b0; ack_n = 0;
    @(negedge i_clk);
    i_req = 1'b1; i_we = we; i_addr = addr; i_funct3 = f3; i_wdata = wd;
    for (int n = 1; n <= 40 && !done; n++) begin
      @(negedge i_clk);
      if (o_ack) begin
        x_acks++;
        if (x_lat == 0) begin
          x_lat = n; ack_n = n;
          x_err = o_err; x_mis = o_misalign; x_rdata = o_rdata;
        end
        i_req = 1'b0;
      end else if (x_lat != 0 && n == ack_n + 1) begin
        x_err_after = o_err | o_misalign | (|o_rdata);
      end
      if (o_bus_cyc) begin
        x_cyc++;
        if (x_cyc == 1) begin
          x_we = o_bus_we; x_addr = o_bus_addr; x_sel = o_bus_sel; x_wdata = o_bus_wdata;
        end else if ({o_bus_we, o_bus_addr, o_bus_sel, o_bus_wdata} !==
                     {x_we, x_addr, x_sel, x_wdata}) begin
          x_unstable++;
        end
        i_bus_ack   = (ack_after != 0) && (x_cyc == ack_after);
        i_bus_rdata = i_bus_ack ? rd_in : 32'h0BAD0BAD;
      end else begin
        i_bus_ack = 1'b0; i_bus_rdata = '0;
      end
      if (x_lat != 0 && n >= ack_n + 3) done = 1'b1;
    end
    i_req = 1'b0; i_bus_ack = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge i_clk);
    n_cmp++;
    if ({o_ack, o_rdata, o_err, o_misalign, o_bus_cyc, o_bus_we, o_bus_addr, o_bus_sel, o_bus_wdata} !== '0) begin
      n_mis++; $display("FAIL reset_outputs: got ack=%b cyc=%b err=%b addr=%h sel=%b want all zero",
                        o_ack, o_bus_cyc, o_err, o_bus_addr, o_bus_sel);
    end
    i_rst_n = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    n_cmp++;
    if ({o_ack, o_err, o_bus_cyc} !== 3'b000) begin
      n_mis++; $display("FAIL idle_after_reset: got ack=%b err=%b cyc=%b want 000", o_ack, o_err, o_bus_cyc);
    end
  endtask

  task automatic test_sb();
    do_xfer(1'b1, 32'h0000_1003, 3'b000, 32'hAABB_CCDD, 3, 32'h5555_5555);
    n_cmp++; if (x_addr !== 32'h0000_1000) begin n_mis++; $display("FAIL sb_addr: got %h want 00001000", x_addr); end
    n_cmp++; if (x_sel !== 4'b1000) begin n_mis++; $display("FAIL sb_sel: got %b want 1000", x_sel); end
    n_cmp++; if (x_wdata !== 32'hDDDD_DDDD) begin n_mis++; $display("FAIL sb_wdata: got %h want dddddddd", x_wdata); end
    n_cmp++; if (x_we !== 1'b1) begin n_mis++; $display("FAIL sb_we: got %b want 1", x_we); end
    n_cmp++; if (x_cyc !== 3) begin n_mis++; $display("FAIL sb_cyc_len: got %0d want 3", x_cyc); end
    n_cmp++; if (x_lat !== 4) begin n_mis++; $display("FAIL sb_ack_lat: got %0d want 4", x_lat); end
    n_cmp++; if (x_acks !== 1) begin n_mis++; $display("FAIL sb_ack_count: got %0d want 1", x_acks); end
    n_cmp++; if (x_err !== 1'b0) begin n_mis++; $display("FAIL sb_err: got %b want 0", x_err); end
    n_cmp++; if (x_rdata !== 32'h0) begin n_mis++; $display("FAIL sb_rdata: got %h want 0", x_rdata); end
    n_cmp++; if (x_unstable !== 0) begin n_mis++; $display("FAIL sb_bus_stable: got %0d changes want 0", x_unstable); end
    n_cmp++; if (x_err_after !== 1'b0) begin n_mis++; $display("FAIL sb_resp_clear: got %b want 0", x_err_after); end
  endtask

  task automatic test_lw();
    do_xfer(1'b0, 32'h0000_2000, 3'b010, 32'h0, 1, 32'h1234_5678);
    n_cmp++; if (x_cyc !== 1) begin n_mis++; $display("FAIL lw_cyc_len: got %0d want 1", x_cyc); end
    n_cmp++; if (x_lat !== 2) begin n_mis++; $display("FAIL lw_ack_lat: got %0d want 2", x_lat); end
    n_cmp++; if (x_rdata !== 32'h1234_5678) begin n_mis++; $display("FAIL lw_rdata: got %h want 12345678", x_rdata); end
    n_cmp++; if (x_err !== 1'b0) begin n_mis++; $display("FAIL lw_err: got %b want 0", x_err); end
    n_cmp++; if ({x_we, x_sel, x_addr} !== {1'b0, 4'b1111, 32'h0000_2000}) begin
      n_mis++; $display("FAIL lw_bus: got we=%b sel=%b addr=%h want we=0 sel=1111 addr=00002000", x_we, x_sel, x_addr);
    end
  endtask

  task automatic test_sh_misalign();
    do_xfer(1'b1, 32'h0000_0001, 3'b001, 32'h1122_3344, 1, 32'h0);
`ifdef DMEM_MISALIGN_TRAP_EN
    n_cmp++; if (x_cyc !== 0) begin n_mis++; $display("FAIL shmis_no_cyc: got %0d want 0", x_cyc); end
    n_cmp++; if (x_lat !== 1) begin n_mis++; $display("FAIL shmis_ack_lat: got %0d want 1", x_lat); end
    n_cmp++; if ({x_err, x_mis} !== 2'b11) begin n_mis++; $display("FAIL shmis_err: got %b%b want 11", x_err, x_mis); end
`else
    n_cmp++; if (x_sel !== 4'b0011) begin n_mis++; $display("FAIL shmis_sel: got %b want 0011", x_sel); end
    n_cmp++; if (x_wdata !== 32'h3344_3344) begin n_mis++; $display("FAIL shmis_wdata: got %h want 33443344", x_wdata); end
    n_cmp++; if (x_addr !== 32'h0) begin n_mis++; $display("FAIL shmis_addr: got %h want 0", x_addr); end
    n_cmp++; if ({x_err, x_mis} !== 2'b00) begin n_mis++; $display("FAIL shmis_err: got %b%b want 00", x_err, x_mis); end
    n_cmp++; if (x_lat !== 2) begin n_mis++; $display("FAIL shmis_ack_lat: got %0d want 2", x_lat); end
`endif
    n_cmp++; if (x_acks !== 1) begin n_mis++; $display("FAIL shmis_ack_count: got %0d want 1", x_acks); end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] wd;
    logic [3:0]  sel;
    logic [31:0] wdata;
  } vec_t;

  task automatic test_lanes();
    vec_t v[7];
    logic [31:0] rd;
    v[0] = '{1'b0, 32'h4000_0001, 3'b000, 32'h0,         4'b0010, 32'h0};
    v[1] = '{1'b0, 32'h4000_0003, 3'b100, 32'h0,         4'b1000, 32'h0};
    v[2] = '{1'b0, 32'h4000_0006, 3'b101, 32'h0,         4'b1100, 32'h0};
    v[3] = '{1'b1, 32'h5000_0002, 3'b000, 32'h1234_5678, 4'b0100, 32'h7878_7878};
    v[4] = '{1'b1, 32'h5000_0000, 3'b001, 32'hCAFE_BABE, 4'b0011, 32'hBABE_BABE};
    v[5] = '{1'b1, 32'h5000_000C, 3'b010, 32'hA5A5_F00F, 4'b1111, 32'hA5A5_F00F};
    v[6] = '{1'b1, 32'h5000_0002, 3'b001, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF};
    for (int i = 0; i < 7; i++) begin
      rd = v[i].addr ^ 32'hFFFF_0000;
      do_xfer(v[i].we, v[i].addr, v[i].f3, v[i].wd, 2, rd);
      n_cmp++;
      if ({x_sel, x_addr, x_we} !== {v[i].sel, v[i].addr & 32'hFFFF_FFFC, v[i].we}) begin
        n_mis++; $display("FAIL lane_%0d_bus: got sel=%b addr=%h we=%b want sel=%b addr=%h we=%b",
                          i, x_sel, x_addr, x_we, v[i].sel, v[i].addr & 32'hFFFF_FFFC, v[i].we);
      end
      if (v[i].we) begin
        n_cmp++;
        if (x_wdata !== v[i].wdata) begin
          n_mis++; $display("FAIL lane_%0d_wdata: got %h want %h", i, x_wdata, v[i].wdata);
        end
      end
      n_cmp++;
      if ({x_err, x_rdata} !== {1'b0, (v[i].we ? 32'h0 : rd)}) begin
        n_mis++; $display("FAIL lane_%0d_resp: got err=%b rdata=%h want err=0 rdata=%h",
                          i, x_err, x_rdata, v[i].we ? 32'h0 : rd);
      end
    end
  endtask

  task automatic test_illegal();
    vec_t v[3];
    v[0] = '{1'b0, 32'h0000_0600, 3'b011, 32'h0,         4'b1111, 32'h0};
    v[1] = '{1'b1, 32'h0000_0601, 3'b100, 32'h0102_0304, 4'b1111, 32'h0102_0304};
    v[2] = '{1'b0, 32'h0000_0702, 3'b010, 32'h0,         4'b1111, 32'h0};
    for (int i = 0; i < 3; i++) begin
      do_xfer(v[i].we, v[i].addr, v[i].f3, v[i].wd, 1, 32'h7777_0000);
`ifdef DMEM_MISALIGN_TRAP_EN
      n_cmp++;
      if ({x_cyc == 0, x_lat == 1, x_err, x_mis} !== 4'b1111) begin
        n_mis++; $display("FAIL illegal_%0d_trap: got cyc=%0d lat=%0d err=%b mis=%b want cyc=0 lat=1 err=1 mis=1",
                          i, x_cyc, x_lat, x_err, x_mis);
      end
`else
      n_cmp++;
      if ({x_sel, x_addr, x_err, x_mis} !== {v[i].sel, v[i].addr & 32'hFFFF_FFFC, 2'b00}) begin
        n_mis++; $display("FAIL illegal_%0d_word: got sel=%b addr=%h err=%b mis=%b want sel=%b addr=%h err=0 mis=0",
                          i, x_sel, x_addr, x_err, x_mis, v[i].sel, v[i].addr & 32'hFFFF_FFFC);
      end
      if (v[i].we) begin
        n_cmp++;
        if (x_wdata !== v[i].wdata) begin
          n_mis++; $display("FAIL illegal_%0d_wdata: got %h want %h", i, x_wdata, v[i].wdata);
        end
      end
`endif
    end
  endtask

  task automatic test_timeout();
    do_xfer(1'b0, 32'h0000_0800, 3'b010, 32'h0, 0, 32'h0);
    n_cmp++; if (x_cyc !== 4) begin n_mis++; $display("FAIL tmo_cyc_len: got %0d want 4", x_cyc); end
    n_cmp++; if (x_lat !== 5) begin n_mis++; $display("FAIL tmo_ack_lat: got %0d want 5", x_lat); end
    n_cmp++; if ({x_err, x_mis} !== 2'b10) begin n_mis++; $display("FAIL tmo_err: got %b%b want 10", x_err, x_mis); end
    n_cmp++; if (x_rdata !== 32'h0) begin n_mis++; $display("FAIL tmo_rdata: got %h want 0", x_rdata); end
    n_cmp++; if (x_err_after !== 1'b0) begin n_mis++; $display("FAIL tmo_resp_clear: got %b want 0", x_err_after); end
    do_xfer(1'b0, 32'h0000_0804, 3'b010, 32'h0, 4, 32'hCAFE_F00D);
    n_cmp++; if (x_cyc !== 4) begin n_mis++; $display("FAIL tmo_edge_cyc_len: got %0d want 4", x_cyc); end
    n_cmp++; if (x_err !== 1'b0) begin n_mis++; $display("FAIL tmo_edge_err: got %b want 0", x_err); end
    n_cmp++; if (x_rdata !== 32'hCAFE_F00D) begin n_mis++; $display("FAIL tmo_edge_rdata: got %h want cafef00d", x_rdata); end
  endtask

  task automatic test_back_to_back();
    int rises, acks, ack_pos[2], rise_pos[2], max_run, run;
    logic prev_cyc;
    logic [3:0]  sel_seen[2];
    logic [31:0] addr_seen[2], wdata_seen[2], rdata_seen[2];
    logic        we_seen[2];
    rises = 0; acks = 0; max_run = 0; run = 0; prev_cyc = 1'b0;
    ack_pos[0] = 0; ack_pos[1] = 0; rise_pos[0] = 0; rise_pos[1] = 0;
    @(negedge i_clk);
    i_req = 1'b1; i_we = 1'b0; i_addr = 32'h0000_2002; i_funct3 = 3'b001; i_wdata = 32'h0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge i_clk);
      if (o_bus_cyc && !prev_cyc) begin
        if (rises < 2) begin
          rise_pos[rises] = n; sel_seen[rises] = o_bus_sel; addr_seen[rises] = o_bus_addr;
          wdata_seen[rises] = o_bus_wdata; we_seen[rises] = o_bus_we;
        end
        rises++;
      end
      prev_cyc = o_bus_cyc;
      i_bus_ack   = o_bus_cyc;
      i_bus_rdata = o_bus_cyc ? 32'h1111_2222 : 32'h0;
      if (o_ack) begin
        run++;
        if (acks < 2) begin ack_pos[acks] = n; rdata_seen[acks] = o_rdata; end
        acks++;
        if (acks == 1) begin
          i_we = 1'b1; i_addr = 32'h0000_3000; i_funct3 = 3'b010; i_wdata = 32'h89AB_CDEF;
        end else begin
          i_req = 1'b0;
        end
      end else begin
        run = 0;
      end
      if (run > max_run) max_run = run;
    end
    i_bus_ack = 1'b0; i_req = 1'b0;
    n_cmp++; if (rises !== 2) begin n_mis++; $display("FAIL b2b_cyc_count: got %0d want 2", rises); end
    n_cmp++; if (acks !== 2) begin n_mis++; $display("FAIL b2b_ack_count: got %0d want 2", acks); end
    n_cmp++; if (max_run !== 1) begin n_mis++; $display("FAIL b2b_ack_width: got %0d want 1", max_run); end
    n_cmp++;
    if ({rise_pos[0], rise_pos[1], ack_pos[0], ack_pos[1]} !== {32'd1, 32'd4, 32'd2, 32'd5}) begin
      n_mis++; $display("FAIL b2b_timing: got cyc@%0d,%0d ack@%0d,%0d want cyc@1,4 ack@2,5",
                        rise_pos[0], rise_pos[1], ack_pos[0], ack_pos[1]);
    end
    n_cmp++;
    if ({sel_seen[0], addr_seen[0], we_seen[0], rdata_seen[0]} !== {4'b1100, 32'h0000_2000, 1'b0, 32'h1111_2222}) begin
      n_mis++; $display("FAIL b2b_first: got sel=%b addr=%h we=%b rdata=%h want sel=1100 addr=00002000 we=0 rdata=11112222",
                        sel_seen[0], addr_seen[0], we_seen[0], rdata_seen[0]);
    end
    n_cmp++;
    if ({sel_seen[1], addr_seen[1], we_seen[1], wdata_seen[1], rdata_seen[1]} !==
        {4'b1111, 32'h0000_3000, 1'b1, 32'h89AB_CDEF, 32'h0}) begin
      n_mis++; $display("FAIL b2b_second: got sel=%b addr=%h we=%b wdata=%h rdata=%h want sel=1111 addr=00003000 we=1 wdata=89abcdef rdata=0",
                        sel_seen[1], addr_seen[1], we_seen[1], wdata_seen[1], rdata_seen[1]);
    end
  endtask

  task automatic test_reset_mid();
    int stray_acks;
    stray_acks = 0;
    @(negedge i_clk);
    i_req = 1'b1; i_we = 1'b0; i_addr = 32'h0000_0900; i_funct3 = 3'b010;
    @(negedge i_clk);
    @(negedge i_clk);
    n_cmp++; if (o_bus_cyc !== 1'b1) begin n_mis++; $display("FAIL rstmid_in_bus: got cyc=%b want 1", o_bus_cyc); end
    #2;
    i_rst_n = 1'b0; i_req = 1'b0;
    #1;
    n_cmp++; if (o_bus_cyc !== 1'b0) begin n_mis++; $display("FAIL rstmid_async_cyc: got %b want 0", o_bus_cyc); end
    n_cmp++;
    if ({o_ack, o_rdata, o_err, o_misalign, o_bus_we, o_bus_addr, o_bus_sel, o_bus_wdata} !== '0) begin
      n_mis++; $display("FAIL rstmid_outputs: got ack=%b err=%b addr=%h sel=%b want all zero",
                        o_ack, o_err, o_bus_addr, o_bus_sel);
    end
    for (int n = 0; n < 2; n++) begin
      @(negedge i_clk);
      if (o_ack) stray_acks++;
    end
    i_rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge i_clk);
      if (o_ack || o_bus_cyc) stray_acks++;
    end
    n_cmp++; if (stray_acks !== 0) begin n_mis++; $display("FAIL rstmid_no_ack: got %0d stray cycles want 0", stray_acks); end
    do_xfer(1'b0, 32'h0000_0A00, 3'b010, 32'h0, 1, 32'h0F0F_1234);
    n_cmp++;
    if ({x_lat, x_rdata} !== {32'd2, 32'h0F0F_1234}) begin
      n_mis++; $display("FAIL rstmid_recover: got lat=%0d rdata=%h want lat=2 rdata=0f0f1234", x_lat, x_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_sb();
    test_lw();
    test_sh_misalign();
    test_lanes();
    test_illegal();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, expected finish", $time);
    $fatal(1, "bench time limit reached");
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory bus controller sitting directly downstream of the pipeline memory stage. It accepts one load/store request at a time, performs lane steering and byte-select generation, and runs a single-outstanding cycle on the data bus. It returns a one-cycle acknowledge with the raw read word, or an error. A watchdog terminates bus cycles that are never acknowledged.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum number of cycles spent in BUS before the cycle is aborted. Legal range is 2..255.
- `i_clk`  in  1  clock
- `i_rst_n`  in  1  reset, asynchronous, active-low
- `i_req`  in  1  request from the memory stage, held high until `o_ack`
- `i_we`  in  1  0 = load, 1 = store
- `i_addr`  in  32  full byte address
- `i_funct3`  in  3  access size and signedness (RV32I load/store encoding)
- `i_wdata`  in  32  unshifted store data (rs2)
- `o_ack`  out  1  one-cycle completion pulse
- `o_rdata`  out  32  raw 32-bit word read from the bus; valid only while `o_ack` is high
- `o_err`  out  1  valid with `o_ack`: timeout or misalignment
- `o_misalign`  out  1  valid with `o_ack`: the error is a misalignment
- `o_bus_cyc`  out  1  bus cycle active
- `o_bus_we`  out  1  bus write
- `o_bus_addr`  out  32  word address, with `[1:0]` forced to 00
- `o_bus_sel`  out  4  byte lane enables
- `o_bus_wdata`  out  32  lane-steered store data
- `i_bus_ack`  in  1  slave acknowledge; sampled only while `o_bus_cyc` is high
- `i_bus_rdata`  in  32  slave read data; valid when `i_bus_ack` is high

## Operation
- FSM has three states: IDLE, BUS, RESP. All outputs are registered.
- **IDLE**
  - When `i_req` is high, latch `i_we`, `i_addr`, `i_funct3` and `i_wdata`, then compute sel and wdata.
  - If the access is legal, assert `o_bus_cyc` and go to BUS.
  - If the access is illegal (trap build only), go to RESP with `o_err=1` and `o_misalign=1`.
- **Byte select**, with `a = i_addr[1:0]`:
  - byte (funct3 000 or 100): `sel = 0001<<a`
  - half (001 or 101): `sel = 0011<<(2*a[1])`
  - word (010): `sel = 1111`
  - Loads use the same sel values.
- **Store data**: byte → `{4{rs2[7:0]}}`; half → `{2{rs2[15:0]}}`; word → `rs2`.
- **Illegal funct3** (011, 110, 111, and store codes above 010) is treated as misaligned.
- **BUS**
  - Bus signals stay stable until `i_bus_ack`.
  - On `i_bus_ack`: capture `i_bus_rdata` (stores capture 0), deassert `o_bus_cyc`, go to RESP.
  - The watchdog counter is cleared on entry and increments every BUS cycle without an ack.
  - When the counter reaches `TIMEOUT_CYCLES-1` with no ack: deassert `o_bus_cyc`, set `o_err=1`, `o_misalign=0`, `o_rdata=0`, go to RESP.
  - An ack arriving on the same cycle as the timeout wins, and no error is raised.
- **RESP**
  - `o_ack=1` for exactly one cycle, then go to IDLE.
  - `o_err`, `o_misalign` and `o_rdata` clear when leaving RESP.
- `i_req` is ignored in BUS and RESP. The first IDLE cycle after RESP accepts `i_req` as a new request (the back-to-back pipeline case).
- Sign and zero extension and byte extraction are not done here; they belong to the memory stage, using `o_rdata` and its own address.

## Timing
- Reset value of every output is 0, and the FSM resets to IDLE.
- Reset asserted mid-BUS drops `o_bus_cyc` immediately (asynchronously). The aborted cycle is not acknowledged.
- Latency: `i_req` is sampled at edge N, `o_bus_cyc` is high from N+1, `i_bus_ack` is sampled at edge M, and `o_ack` is high in the cycle after M.
- With a zero-wait slave (ack in the first `cyc` cycle), `o_ack` is high 2 cycles after request acceptance. A misalign trap gives `o_ack` 1 cycle after acceptance, with no bus cycle.
- Timeout: with no ack, `o_bus_cyc` stays high for exactly `TIMEOUT_CYCLES` cycles, and `o_ack` follows in the next cycle.
- `o_bus_cyc` never stays high for two bus transactions without an intervening low cycle.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined:
  - A misaligned or illegal access skips the bus.
  - It produces `o_ack` with `o_err=1` and `o_misalign=1`.
- Undefined:
  - `o_misalign` is tied to 0.
  - Misaligned halves are forced to halfword alignment (`a[0]` ignored), and misaligned words are forced to word alignment.
  - An illegal funct3 is treated as a word access.
  - The bus cycle proceeds normally.

## Test plan
- **SB:** `i_addr=0x1003`, `i_wdata=0xAABBCCDD`, slave acks after 3 cycles → `o_bus_addr=0x1000`, `sel=1000`, `wdata=0xDDDDDDDD`, `we=1`, `cyc` high for 3 cycles, `o_ack` on the next cycle, `o_err=0`.
- **LW:** `i_addr=0x2000`, slave acks in the first cycle with `0x12345678` → `o_ack` 2 cycles after acceptance with `o_rdata=0x12345678`.
- **SH misaligned:** `i_addr=0x0001`.
  - Trap build: no `cyc`, `o_ack` with `o_err=1` and `o_misalign=1`.
  - Non-trap build: `sel=0011`, `wdata={2{rs2[15:0]}}`.
- **Timeout:** `TIMEOUT_CYCLES=4`, slave never acks → `cyc` high for exactly 4 cycles, then `o_ack` with `o_err=1`, `o_misalign=0`, `o_rdata=0`. Repeat with ack on cycle 4 → `o_err=0`.
- **Back-to-back:** `i_req` held high across a first request (LH at `0x2002`, `sel=1100`), then a second request (SW at `0x3000`) → two distinct bus cycles separated by a low `cyc` cycle, and two single-cycle `o_ack` pulses.
- **Reset mid-operation:** `i_rst_n` pulsed low during BUS → `o_bus_cyc=0` immediately, no `o_ack`, FSM in IDLE, all outputs 0.
